axi_stream_input: RTL and testbench



---
 rtl/axi_stream_input.sv | 132 +++++++++++++
 tb/tb_axi_stream_input.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_input.sv
// AXI4-Stream slave ingest: packs DATA_WIDTH beats into SRAM_WIDTH words (lane 0 in LSBs)
// and writes them to the input SRAM at consecutive addresses from 0, then pulses input_done.
module axi_stream_input #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int SRAM_WIDTH         = 64,
  parameter int NUM_CHANNELS_WIDTH = $clog2(64 + 1),
  parameter int SIZE_WIDTH         = ADDR_WIDTH + $clog2(SRAM_WIDTH / DATA_WIDTH)
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
  output logic                          sram_in_en,
  output logic [ADDR_WIDTH-1:0]         sram_in_addr,
  output logic [SRAM_WIDTH-1:0]         sram_in_data,
  input  logic                          start_input,
  input  logic [SIZE_WIDTH-1:0]         in_size,
  output logic                          input_done,
  output logic                          input_error,
  output logic [ADDR_WIDTH:0]           words_written,
  output logic [1:0]                    state_dbg
);

  localparam int LANES  = SRAM_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t                  state, state_next;
  logic [LANE_W-1:0]       lane_cnt;
  logic [SIZE_WIDTH-1:0]   elem_cnt;
  logic [SIZE_WIDTH-1:0]   size_q;
  logic [SRAM_WIDTH-1:0]   pack_reg;
  logic [SRAM_WIDTH-1:0]   pack_next;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    beat_acc;
  logic                    last_elem;
  logic                    lane_full;
  logic                    word_end;
  logic                    unused_tuser;

  assign unused_tuser = ^s_axis_tuser;

  // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
  // tdata/tlast are don't-care otherwise. tready depends only on state, never on tvalid.
  assign beat_acc  = s_axis_tvalid & s_axis_tready;
  assign last_elem = (elem_cnt + SIZE_WIDTH'(1)) == size_q;
  assign lane_full = lane_cnt == LANE_W'(LANES - 1);
  assign word_end  = lane_full | last_elem | s_axis_tlast;

  always_comb begin
    pack_next = pack_reg;
    for (int i = 0; i < LANES; i++) begin
      if (lane_cnt == LANE_W'(i)) begin
        pack_next[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_input) state_next = (in_size == '0) ? DONE : RECV;
      RECV:    if (beat_acc && (last_elem || s_axis_tlast)) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = (state == RECV);
    input_done    = (state == DONE);
    state_dbg     = state;
  end

  // Datapath: the word that a beat completes is presented on the SRAM port the next cycle.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      size_q        <= '0;
      lane_cnt      <= '0;
      elem_cnt      <= '0;
      pack_reg      <= '0;
      word_idx      <= '0;
      sram_in_en    <= 1'b0;
      sram_in_addr  <= '0;
      sram_in_data  <= '0;
      input_error   <= 1'b0;
      words_written <= '0;
    end else begin
      sram_in_en <= 1'b0;
      if (state == IDLE && start_input) begin
        size_q        <= in_size;
        lane_cnt      <= '0;
        elem_cnt      <= '0;
        pack_reg      <= '0;
        word_idx      <= '0;
        words_written <= '0;
        input_error   <= 1'b0;
      end else if (beat_acc) begin
        elem_cnt <= elem_cnt + SIZE_WIDTH'(1);
        if (word_end) begin
          sram_in_en    <= 1'b1;
          sram_in_addr  <= word_idx;
          sram_in_data  <= pack_next;
          word_idx      <= word_idx + ADDR_WIDTH'(1);
          words_written <= words_written + (ADDR_WIDTH + 1)'(1);
          lane_cnt      <= '0;
          pack_reg      <= '0;
        end else begin
          lane_cnt <= lane_cnt + LANE_W'(1);
          pack_reg <= pack_next;
        end
        // tlast must coincide exactly with the final element
        if (last_elem != s_axis_tlast) input_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_input.sv
// Self-checking bench for axi_stream_input: directed and randomized transfers scored
// against a byte-list reference model of the packing and termination rules.
module tb_axi_stream_input;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int SW    = 64;
  localparam int NCW   = 7;
  localparam int SZW   = 16;
  localparam int LANES = SW / DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic [NCW-1:0] s_axis_tuser;
  logic           sram_in_en;
  logic [AW-1:0]  sram_in_addr;
  logic [SW-1:0]  sram_in_data;
  logic           start_input;
  logic [SZW-1:0] in_size;
  logic           input_done;
  logic           input_error;
  logic [AW:0]    words_written;
  logic [1:0]     state_dbg;

  axi_stream_input dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .sram_in_en    (sram_in_en),
    .sram_in_addr  (sram_in_addr),
    .sram_in_data  (sram_in_data),
    .start_input   (start_input),
    .in_size       (in_size),
    .input_done    (input_done),
    .input_error   (input_error),
    .words_written (words_written),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- monitor ----------------
  logic [AW-1:0] got_addr[$];
  logic [SW-1:0] got_data[$];
  int            got_cyc[$];
  int            done_cyc[$];
  int            ready_cnt;

  always @(negedge clk) begin
    if (sram_in_en) begin
      got_addr.push_back(sram_in_addr);
      got_data.push_back(sram_in_data);
      got_cyc.push_back(cyc);
    end
    if (input_done) done_cyc.push_back(cyc);
    if (s_axis_tready) ready_cnt++;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [SW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cyc.delete();
    ready_cnt = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = DW'($urandom);
      s_axis_tlast  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic last, output int stamp);
    int guard = 0;
    while (!s_axis_tready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!s_axis_tready) check("ready_timeout", s_axis_tready, 1);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = NCW'($urandom);
    @(posedge clk); #1;
    stamp         = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = DW'($urandom);
    s_axis_tlast  = 1'($urandom_range(0, 1));
  endtask

  // One transfer: n beats sent, tl = tlast on the last sent beat; base<0 means random data.
  task automatic run_xfer(input string name, input int size, input int n, input logic tl,
                          input int base, input int gap_at, input int gap_len, input bit rnd_gap);
    logic [DW-1:0] data[$];
    int            acc[$];
    int            stamp;
    int            start_stamp;
    int            guard;
    int            n_words;
    logic          exp_err;
    logic [SW-1:0] w;

    data.delete();
    acc.delete();
    for (int i = 0; i < n; i++) data.push_back((base < 0) ? DW'($urandom) : DW'(base + i));
    clear_mon();

    in_size     = SZW'(size);
    start_input = 1'b1;
    @(posedge clk); #1;
    start_stamp = cyc;
    check({name, "_err_clr"}, input_error, 0);
    check({name, "_ww_clr"}, words_written, 0);
    in_size = SZW'($urandom);

    for (int i = 0; i < n; i++) begin
      if (rnd_gap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (i == gap_at) idle(gap_len);
      drive_beat(data[i], (i == n - 1) ? tl : 1'b0, stamp);
      acc.push_back(stamp);
    end

    guard = 0;
    while (!input_done && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_done_seen"}, input_done, 1);
    start_input = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reference: accepted bytes split into LANES-byte words, last one zero-padded.
    n_words = (n + LANES - 1) / LANES;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int k = 0; k < n_words; k++) begin
      w = '0;
      for (int j = 0; j < LANES; j++)
        if (k * LANES + j < n) w[j*DW +: DW] = data[k * LANES + j];
      exp_q.push_back(w);
      exp_cyc_q.push_back(acc[(k * LANES + LANES - 1 < n) ? k * LANES + LANES - 1 : n - 1]);
    end
    exp_err = (size > 0) && !(n == size && tl);

    check({name, "_nwrites"}, got_data.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_data.size(); k++) begin
      check($sformatf("%s_addr%0d", name, k), got_addr[k], k);
      check($sformatf("%s_data%0d", name, k), got_data[k], exp_q[k]);
      check($sformatf("%s_wlat%0d", name, k), got_cyc[k], exp_cyc_q[k]);
    end
    check({name, "_words_written"}, words_written, n_words);
    check({name, "_error"}, input_error, exp_err);
    check({name, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      if (n > 0) check({name, "_done_lat"}, done_cyc[0], acc[n-1] + 1);
      else check({name, "_done_lat0"}, (done_cyc[0] - start_stamp) <= 2, 1);
    end
    check({name, "_tready_after"}, s_axis_tready, 0);
    if (size == 0) check({name, "_tready_never"}, ready_cnt, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int stamp;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    start_input   = 1'b0;
    in_size       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", sram_in_en, 0);
    check("rst_addr", sram_in_addr, 0);
    check("rst_data", sram_in_data, 0);
    check("rst_done", input_done, 0);
    check("rst_err", input_error, 0);
    check("rst_ww", words_written, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_xfer("t16", 16, 16, 1'b1, 1, -1, 0, 1'b0);
    if (exp_q.size() == 2) begin
      check("t16_lit0", exp_q[0], 64'h0807060504030201);
      check("t16_lit1", got_data.size() > 1 ? got_data[1] : '0, 64'h100F0E0D0C0B0A09);
    end
    run_xfer("t5gap", 5, 5, 1'b1, 8'hA1, 2, 3, 1'b0);
    check("t5gap_lit", got_data.size() > 0 ? got_data[0] : '0, 64'h000000A5A4A3A2A1);
    run_xfer("early", 8, 3, 1'b1, 1, -1, 0, 1'b0);
    check("early_lit", got_data.size() > 0 ? got_data[0] : '0, 64'h0000000000030201);
    run_xfer("notlast", 4, 4, 1'b0, 1, -1, 0, 1'b0);
    run_xfer("zero", 0, 0, 1'b0, 0, -1, 0, 1'b0);

    // Asynchronous reset in the middle of a 16-element transfer
    clear_mon();
    in_size     = SZW'(16);
    start_input = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) drive_beat(DW'(i + 1), 1'b0, stamp);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en", sram_in_en, 0);
    check("arst_addr", sram_in_addr, 0);
    check("arst_data", sram_in_data, 0);
    check("arst_err", input_error, 0);
    check("arst_ww", words_written, 0);
    check("arst_tready", s_axis_tready, 0);
    check("arst_state", state_dbg, 0);
    start_input = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("arst_nwrites", got_data.size(), 1);
    check("arst_ndone", done_cyc.size(), 0);
    run_xfer("post_rst", 8, 8, 1'b1, 8'h30, -1, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int size;
      int mode;
      int n;
      logic tl;
      size = $urandom_range(1, 40);
      mode = $urandom_range(0, 2);
      n    = (mode == 2) ? $urandom_range(1, size) : size;
      tl   = (mode != 1);
      run_xfer($sformatf("rnd%0d", t), size, n, tl, -1, -1, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
